// File: rtl/core_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_seq_ctrl : multi-cycle RV32I sequencer over one shared bus    |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module core_seq_ctrl #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fault,
  input  logic [1:0]  mem_op,
  input  logic [1:0]  wb_op,
  input  logic [1:0]  jmp_op,
  input  logic        branch_taken,
  input  logic        halt_req,
  input  logic        bus_ready,
  output logic        bus_req,
  output logic        bus_sel,
  output logic        bus_we,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_t;

  // The counter never has to hold more than BUS_TIMEOUT-1.
  localparam int              CNT_W    = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      instret_q, instret_d;
  logic [1:0]       cause_q,   cause_d;

  logic w_req, w_sel, w_we, w_ir, w_mdr, w_rf, w_pc, w_pcs;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instret_d = instret_q;
    cause_d   = cause_q;
    w_req     = 1'b0;
    w_sel     = 1'b0;
    w_we      = 1'b0;
    w_ir      = 1'b0;
    w_mdr     = 1'b0;
    w_rf      = 1'b0;
    w_pc      = 1'b0;
    w_pcs     = 1'b0;

    case (state_q)
      FETCH: begin
        // A zero counter marks the first FETCH cycle, the only one where halt is honoured.
        if ((cnt_q == '0) && halt_req) begin
          state_d = HALT;
        end else begin
          w_req = 1'b1;
          if (bus_ready) begin
            w_ir    = 1'b1;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        if (fault) begin
          state_d = TRAP;
          cause_d = 2'd1;
        end else if ((&mem_op) || (&wb_op) || (&jmp_op)) begin
          state_d = TRAP;
          cause_d = 2'd2;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = (mem_op != 2'd0) ? MEM : WB;
      end
      MEM: begin
        w_req = 1'b1;
        w_sel = 1'b1;
        w_we  = (mem_op == 2'd2);
        if (bus_ready) begin
          w_mdr   = (mem_op == 2'd1);
          state_d = WB;
        end
      end
      WB: begin
        w_rf      = (wb_op != 2'd0);
        w_pc      = 1'b1;
        w_pcs     = (jmp_op == 2'd1) || ((jmp_op == 2'd2) && branch_taken);
        instret_d = instret_q + 32'd1;
        state_d   = FETCH;
      end
      HALT: begin
        if (!halt_req) begin
          state_d = FETCH;
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (w_req && !bus_ready) begin
      if (cnt_q == CNT_LAST) begin
        state_d = TRAP;
        cause_d = 2'd3;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (w_req && bus_ready) begin
      cnt_d = '0;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      instret_q <= 32'd0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
      cause_q   <= cause_d;
    end
  end

  // Strobes are forced low while reset is held so an abandoned transfer cannot write.
  assign bus_req    = w_req & ~rst;
  assign bus_sel    = w_sel & ~rst;
  assign bus_we     = w_we  & ~rst;
  assign ir_we      = w_ir  & ~rst;
  assign mdr_we     = w_mdr & ~rst;
  assign rf_we      = w_rf  & ~rst;
  assign pc_we      = w_pc  & ~rst;
  assign pc_sel     = w_pcs & ~rst;
  assign state      = state_q;
  assign halted     = (state_q == HALT);
  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_core_seq_ctrl : directed-vector scoreboard bench for the core   |
// | sequencer (BUS_TIMEOUT = 4). Revision 1.0                          |
// +--------------------------------------------------------------------+
module tb_core_seq_ctrl;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_DEC   = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;
  localparam logic [2:0] ST_TRAP  = 3'd6;

  // Strobe vector: {bus_req,bus_sel,bus_we,ir_we,mdr_we,rf_we,pc_we,pc_sel,halted,trap}
  localparam logic [9:0] NONE = 10'b0000000000;
  localparam logic [9:0] REQ  = 10'b1000000000;
  localparam logic [9:0] SEL  = 10'b0100000000;
  localparam logic [9:0] WE   = 10'b0010000000;
  localparam logic [9:0] IRW  = 10'b0001000000;
  localparam logic [9:0] MDR  = 10'b0000100000;
  localparam logic [9:0] RF   = 10'b0000010000;
  localparam logic [9:0] PC   = 10'b0000001000;
  localparam logic [9:0] PCS  = 10'b0000000100;
  localparam logic [9:0] HLT  = 10'b0000000010;
  localparam logic [9:0] TRP  = 10'b0000000001;

  logic        clk;
  logic        rst;
  logic        fault;
  logic [1:0]  mem_op;
  logic [1:0]  wb_op;
  logic [1:0]  jmp_op;
  logic        branch_taken;
  logic        halt_req;
  logic        bus_ready;
  logic        bus_req;
  logic        bus_sel;
  logic        bus_we;
  logic        ir_we;
  logic        mdr_we;
  logic        rf_we;
  logic        pc_we;
  logic        pc_sel;
  logic [2:0]  state;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  logic [46:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  core_seq_ctrl #(.BUS_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .fault        (fault),
    .mem_op       (mem_op),
    .wb_op        (wb_op),
    .jmp_op       (jmp_op),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .bus_ready    (bus_ready),
    .bus_req      (bus_req),
    .bus_sel      (bus_sel),
    .bus_we       (bus_we),
    .ir_we        (ir_we),
    .mdr_we       (mdr_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .state        (state),
    .halted       (halted),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic tick(input string nm, input logic [2:0] st, input logic [9:0] sb,
                      input logic [1:0] cs, input logic [31:0] ir);
    exp_q.push_back({st, sb, cs, ir});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic ops(input logic [1:0] m, input logic [1:0] w, input logic [1:0] j);
    mem_op = m;
    wb_op  = w;
    jmp_op = j;
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the queue head.
  always @(negedge clk) begin
    logic [46:0] act;
    logic [46:0] e;
    string       n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = {state, bus_req, bus_sel, bus_we, ir_we, mdr_we, rf_we, pc_we, pc_sel,
             halted, trap, trap_cause, instret};
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got state=%0d strobes=%b cause=%0d instret=%0d, expected state=%0d strobes=%b cause=%0d instret=%0d",
                 n, act[46:44], act[43:34], act[33:32], act[31:0],
                 e[46:44], e[43:34], e[33:32], e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; fault = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; bus_ready = 1'b0;
    ops(2'd0, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    tick("reset", ST_FETCH, NONE, 2'd0, 32'd0);
    rst = 1'b0;

    // ADD, zero-wait
    ops(2'd0, 2'd1, 2'd0); bus_ready = 1'b1;
    tick("add_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd0);
    tick("add_dec",   ST_DEC,   NONE,      2'd0, 32'd0);
    tick("add_exec",  ST_EXEC,  NONE,      2'd0, 32'd0);
    tick("add_wb",    ST_WB,    RF | PC,   2'd0, 32'd0);

    // SW with two wait cycles
    ops(2'd2, 2'd0, 2'd0);
    tick("sw_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd1);
    tick("sw_dec",   ST_DEC,   NONE,      2'd0, 32'd1);
    tick("sw_exec",  ST_EXEC,  NONE,      2'd0, 32'd1);
    bus_ready = 1'b0;
    tick("sw_mem0",  ST_MEM, REQ | SEL | WE, 2'd0, 32'd1);
    tick("sw_mem1",  ST_MEM, REQ | SEL | WE, 2'd0, 32'd1);
    bus_ready = 1'b1;
    tick("sw_mem2",  ST_MEM, REQ | SEL | WE, 2'd0, 32'd1);
    tick("sw_wb",    ST_WB,  PC,             2'd0, 32'd1);

    // BNE taken, then not taken
    ops(2'd0, 2'd0, 2'd2); branch_taken = 1'b1;
    tick("bne_t_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd2);
    tick("bne_t_dec",   ST_DEC,   NONE,      2'd0, 32'd2);
    tick("bne_t_exec",  ST_EXEC,  NONE,      2'd0, 32'd2);
    tick("bne_t_wb",    ST_WB,    PC | PCS,  2'd0, 32'd2);
    branch_taken = 1'b0;
    tick("bne_n_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd3);
    tick("bne_n_dec",   ST_DEC,   NONE,      2'd0, 32'd3);
    tick("bne_n_exec",  ST_EXEC,  NONE,      2'd0, 32'd3);
    tick("bne_n_wb",    ST_WB,    PC,        2'd0, 32'd3);

    // LW with one wait cycle
    ops(2'd1, 2'd1, 2'd0);
    tick("lw_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd4);
    tick("lw_dec",   ST_DEC,   NONE,      2'd0, 32'd4);
    tick("lw_exec",  ST_EXEC,  NONE,      2'd0, 32'd4);
    bus_ready = 1'b0;
    tick("lw_mem0",  ST_MEM, REQ | SEL,       2'd0, 32'd4);
    bus_ready = 1'b1;
    tick("lw_mem1",  ST_MEM, REQ | SEL | MDR, 2'd0, 32'd4);
    tick("lw_wb",    ST_WB,  RF | PC,         2'd0, 32'd4);

    // JAL
    ops(2'd0, 2'd1, 2'd1);
    tick("jal_fetch", ST_FETCH, REQ | IRW,     2'd0, 32'd5);
    tick("jal_dec",   ST_DEC,   NONE,          2'd0, 32'd5);
    tick("jal_exec",  ST_EXEC,  NONE,          2'd0, 32'd5);
    tick("jal_wb",    ST_WB,    RF | PC | PCS, 2'd0, 32'd5);

    // Fetch ready arrives on the 4th request cycle: completes, no trap
    ops(2'd0, 2'd1, 2'd0); bus_ready = 1'b0;
    tick("fw_fetch0", ST_FETCH, REQ, 2'd0, 32'd6);
    tick("fw_fetch1", ST_FETCH, REQ, 2'd0, 32'd6);
    tick("fw_fetch2", ST_FETCH, REQ, 2'd0, 32'd6);
    bus_ready = 1'b1;
    tick("fw_fetch3", ST_FETCH, REQ | IRW, 2'd0, 32'd6);
    tick("fw_dec",    ST_DEC,   NONE,      2'd0, 32'd6);
    tick("fw_exec",   ST_EXEC,  NONE,      2'd0, 32'd6);
    tick("fw_wb",     ST_WB,    RF | PC,   2'd0, 32'd6);

    // Halt raised during EXEC: instruction retires, then HALT
    tick("h_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd7);
    tick("h_dec",   ST_DEC,   NONE,      2'd0, 32'd7);
    halt_req = 1'b1;
    tick("h_exec",  ST_EXEC,  NONE,      2'd0, 32'd7);
    tick("h_wb",    ST_WB,    RF | PC,   2'd0, 32'd7);
    tick("h_entry", ST_FETCH, NONE,      2'd0, 32'd8);
    tick("h_halt0", ST_HALT,  HLT,       2'd0, 32'd8);
    halt_req = 1'b0;
    tick("h_halt1", ST_HALT,  HLT,       2'd0, 32'd8);

    // Resume with a store, reset asserted mid-transfer
    ops(2'd2, 2'd0, 2'd0);
    tick("rs_fetch", ST_FETCH, REQ | IRW,      2'd0, 32'd8);
    tick("rs_dec",   ST_DEC,   NONE,           2'd0, 32'd8);
    tick("rs_exec",  ST_EXEC,  NONE,           2'd0, 32'd8);
    bus_ready = 1'b0;
    tick("rs_mem",   ST_MEM,   REQ | SEL | WE, 2'd0, 32'd8);
    rst = 1'b1;
    tick("rs_rst",   ST_MEM,   NONE,           2'd0, 32'd8);
    rst = 1'b0;

    // ADD after reset, then a decode fault
    ops(2'd0, 2'd1, 2'd0); bus_ready = 1'b1;
    tick("ra_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd0);
    tick("ra_dec",   ST_DEC,   NONE,      2'd0, 32'd0);
    tick("ra_exec",  ST_EXEC,  NONE,      2'd0, 32'd0);
    tick("ra_wb",    ST_WB,    RF | PC,   2'd0, 32'd0);
    tick("df_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd1);
    fault = 1'b1;
    tick("df_dec",   ST_DEC,   NONE,      2'd0, 32'd1);
    fault = 1'b0;
    tick("df_trap0", ST_TRAP,  TRP,       2'd1, 32'd1);
    tick("df_trap1", ST_TRAP,  TRP,       2'd1, 32'd1);
    rst = 1'b1;
    tick("df_rst",   ST_TRAP,  TRP,       2'd1, 32'd1);
    rst = 1'b0;

    // Illegal jmp_op
    ops(2'd0, 2'd0, 2'd3);
    tick("il_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd0);
    tick("il_dec",   ST_DEC,   NONE,      2'd0, 32'd0);
    tick("il_trap",  ST_TRAP,  TRP,       2'd2, 32'd0);
    rst = 1'b1;
    tick("il_rst",   ST_TRAP,  TRP,       2'd2, 32'd0);
    rst = 1'b0;

    // Fetch timeout: four unanswered request cycles
    ops(2'd0, 2'd1, 2'd0); bus_ready = 1'b0;
    tick("ft_fetch0", ST_FETCH, REQ,  2'd0, 32'd0);
    tick("ft_fetch1", ST_FETCH, REQ,  2'd0, 32'd0);
    tick("ft_fetch2", ST_FETCH, REQ,  2'd0, 32'd0);
    tick("ft_fetch3", ST_FETCH, REQ,  2'd0, 32'd0);
    tick("ft_trap0",  ST_TRAP,  TRP,  2'd3, 32'd0);
    bus_ready = 1'b1;
    tick("ft_trap1",  ST_TRAP,  TRP,  2'd3, 32'd0);
    rst = 1'b1;
    tick("ft_rst",    ST_TRAP,  TRP,  2'd3, 32'd0);
    rst = 1'b0;

    // Load timeout in MEM
    ops(2'd1, 2'd1, 2'd0);
    tick("mt_fetch", ST_FETCH, REQ | IRW, 2'd0, 32'd0);
    tick("mt_dec",   ST_DEC,   NONE,      2'd0, 32'd0);
    tick("mt_exec",  ST_EXEC,  NONE,      2'd0, 32'd0);
    bus_ready = 1'b0;
    tick("mt_mem0",  ST_MEM,   REQ | SEL, 2'd0, 32'd0);
    tick("mt_mem1",  ST_MEM,   REQ | SEL, 2'd0, 32'd0);
    tick("mt_mem2",  ST_MEM,   REQ | SEL, 2'd0, 32'd0);
    tick("mt_mem3",  ST_MEM,   REQ | SEL, 2'd0, 32'd0);
    tick("mt_trap",  ST_TRAP,  TRP,       2'd3, 32'd0);
    rst = 1'b1;
    tick("mt_rst",   ST_TRAP,  TRP,       2'd3, 32'd0);
    rst = 1'b0;
    tick("final_fetch", ST_FETCH, REQ,    2'd0, 32'd0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
